// File: rtl/result_readback_pkg.sv
// Shared types and default sizing for the result SRAM readback path.
//   - state_t      : drain FSM states
//   - DEFAULT_*    : default geometry of the result SRAM word
//   - WORD_W       : bits per SRAM word (all lanes packed)
//   - LANE_CNT_W   : width of a lane index
package result_readback_pkg;

   localparam int DEFAULT_ADDRESSSIZE    = 10;
   localparam int DEFAULT_MATRIX_SIZE    = 8;
   localparam int DEFAULT_PARTIAL_SUM_BW = 20;

   localparam int WORD_W     = DEFAULT_PARTIAL_SUM_BW * DEFAULT_MATRIX_SIZE;
   localparam int LANE_CNT_W = (DEFAULT_MATRIX_SIZE > 1) ? $clog2(DEFAULT_MATRIX_SIZE) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/result_readback_if.sv
// Valid/ready stream carrying one signed partial sum per beat.
//   m_valid : source has a lane on m_data
//   m_ready : sink accepts the lane this cycle
//   m_data  : raw partial-sum bits
//   m_last  : final lane of the final word of a drain
// master = producer (result_readback), slave = consumer (host side).
interface result_readback_if
   import result_readback_pkg::*;
#(
   parameter int DATA_W = DEFAULT_PARTIAL_SUM_BW
) ();

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/result_readback_psum_word_serializer.sv
// Holds one SRAM word and presents it lane by lane, lane 0 first.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture word and restart at lane 0
//   shift     : current lane consumed, advance to the next
//   word      : packed lanes, lane 0 in the low bits
//   lane      : lane currently presented
//   last_lane : the presented lane is the final one of the word
module psum_word_serializer
   import result_readback_pkg::*;
#(
   parameter int LANES  = DEFAULT_MATRIX_SIZE,
   parameter int LANE_W = DEFAULT_PARTIAL_SUM_BW,
   parameter int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    shift,
   input  logic [LANES*LANE_W-1:0] word,
   output logic [LANE_W-1:0]       lane,
   output logic                    last_lane
);

   logic [LANES*LANE_W-1:0] shreg_r;
   logic [CNT_W-1:0]        cnt_r;

   // Word shift register and lane counter; shifting right exposes the next lane.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_r <= {(LANES*LANE_W){1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else if (load) begin
         shreg_r <= word;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (shift) begin
         shreg_r <= shreg_r >> LANE_W;
         cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         shreg_r <= shreg_r;
         cnt_r   <= cnt_r;
      end
   end

   assign lane      = shreg_r[LANE_W-1:0];
   assign last_lane = (cnt_r == CNT_W'(LANES - 1));

endmodule

// File: rtl/result_readback.sv
// Drains a range of the result SRAM and streams each word lane by lane.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a drain (ignored while busy)
//   base_addr         : first SRAM address, sampled on accepted start
//   num_words         : words to drain, sampled on accepted start,
//                       values above 2^ADDRESSSIZE are clamped
//   sram_write_enable : constant 0, this block only reads
//   sram_address      : read address, data returns one cycle later
//   sram_data_out     : SRAM read data
//   strm              : valid/ready output stream (master side)
//   busy              : drain in progress, through the done cycle
//   done              : one-cycle pulse after the final handshake
module result_readback
   import result_readback_pkg::*;
#(
   parameter int ADDRESSSIZE    = DEFAULT_ADDRESSSIZE,
   parameter int MATRIX_SIZE    = DEFAULT_MATRIX_SIZE,
   parameter int PARTIAL_SUM_BW = DEFAULT_PARTIAL_SUM_BW
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [ADDRESSSIZE-1:0]              base_addr,
   input  logic [ADDRESSSIZE:0]                num_words,
   output logic                                sram_write_enable,
   output logic [ADDRESSSIZE-1:0]              sram_address,
   input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_data_out,
   result_readback_if.master                   strm,
   output logic                                busy,
   output logic                                done
);

   localparam int LANE_BITS = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
   localparam logic [ADDRESSSIZE:0] MAX_WORDS = {1'b1, {ADDRESSSIZE{1'b0}}};
   localparam logic [ADDRESSSIZE:0] ONE_W     = {{ADDRESSSIZE{1'b0}}, 1'b1};

   state_t                  state_r;
   state_t                  state_s;
   logic [ADDRESSSIZE-1:0]  base_r;
   logic [ADDRESSSIZE:0]    num_r;
   logic [ADDRESSSIZE:0]    word_idx_r;
   logic [ADDRESSSIZE:0]    num_cap_s;
   logic [ADDRESSSIZE-1:0]  next_addr_s;
   logic [PARTIAL_SUM_BW-1:0] lane_s;
   logic                    last_lane_s;
   logic                    accept_s;
   logic                    handshake_s;
   logic                    word_done_s;
   logic                    more_words_s;

   assign accept_s     = (state_r == IDLE) && start;
   assign handshake_s  = (state_r == SEND) && strm.m_ready;
   assign word_done_s  = handshake_s && last_lane_s;
   // word_idx_r never exceeds 2^ADDRESSSIZE-1 while sending, so +1 cannot overflow.
   assign more_words_s = ((word_idx_r + ONE_W) < num_r);
   assign num_cap_s    = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
   // Address of the following word; the truncation gives the silent wrap.
   assign next_addr_s  = base_r + word_idx_r[ADDRESSSIZE-1:0]
                         + {{(ADDRESSSIZE-1){1'b0}}, 1'b1};

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (num_words == {(ADDRESSSIZE+1){1'b0}}) begin
                  state_s = DONE;
               end else begin
                  state_s = ADDR;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ADDR: state_s = WAIT;
         WAIT: state_s = SEND;
         SEND: begin
            if (word_done_s) begin
               if (more_words_s) begin
                  state_s = ADDR;
               end else begin
                  state_s = DONE;
               end
            end else begin
               state_s = SEND;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Drain parameters, word index and read address; the address is set up
   // on the edge that enters ADDR so it is stable for the whole ADDR cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_r       <= {ADDRESSSIZE{1'b0}};
         num_r        <= {(ADDRESSSIZE+1){1'b0}};
         word_idx_r   <= {(ADDRESSSIZE+1){1'b0}};
         sram_address <= {ADDRESSSIZE{1'b0}};
      end else if (accept_s) begin
         base_r       <= base_addr;
         num_r        <= num_cap_s;
         word_idx_r   <= {(ADDRESSSIZE+1){1'b0}};
         sram_address <= base_addr;
      end else if (word_done_s) begin
         word_idx_r   <= word_idx_r + ONE_W;
         sram_address <= next_addr_s;
      end else begin
         base_r       <= base_r;
         num_r        <= num_r;
         word_idx_r   <= word_idx_r;
         sram_address <= sram_address;
      end
   end

   // Read data is valid during WAIT and is captured at the end of it.
   psum_word_serializer #(
      .LANES  (MATRIX_SIZE),
      .LANE_W (PARTIAL_SUM_BW),
      .CNT_W  (LANE_BITS)
   ) u_serializer (
      .clk       (clk),
      .rst       (rst),
      .load      (state_r == WAIT),
      .shift     (handshake_s),
      .word      (sram_data_out),
      .lane      (lane_s),
      .last_lane (last_lane_s)
   );

   // All stream outputs decode registered state only, so m_valid is
   // independent of m_ready and the beat holds while stalled.
   assign strm.m_valid = (state_r == SEND);
   assign strm.m_data  = lane_s;
   assign strm.m_last  = (state_r == SEND) && last_lane_s
                         && (word_idx_r == (num_r - ONE_W));

   assign busy              = (state_r != IDLE);
   assign done              = (state_r == DONE);
   assign sram_write_enable = 1'b0;

endmodule

// File: tb/tb_result_readback.sv
module tb_result_readback;
   import result_readback_pkg::*;

   localparam int AW = 10;
   localparam int MS = 8;
   localparam int PW = 20;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [AW-1:0]     base_addr;
   logic [AW:0]       num_words;
   logic              sram_write_enable;
   logic [AW-1:0]     sram_address;
   logic [PW*MS-1:0]  sram_data_out;
   logic              busy;
   logic              done;

   result_readback_if #(.DATA_W(PW)) strm ();

   result_readback #(
      .ADDRESSSIZE    (AW),
      .MATRIX_SIZE    (MS),
      .PARTIAL_SUM_BW (PW)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .base_addr         (base_addr),
      .num_words         (num_words),
      .sram_write_enable (sram_write_enable),
      .sram_address      (sram_address),
      .sram_data_out     (sram_data_out),
      .strm              (strm),
      .busy              (busy),
      .done              (done)
   );

   always #5 clk = ~clk;

   // SRAM model: one-cycle read latency
   logic [PW*MS-1:0] mem [0:1023];
   always @(posedge clk) sram_data_out <= mem[sram_address];

   int n_checks = 0;
   int n_fails  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // cycle bookkeeping and stream monitor
   int edge_cnt = 0;
   int base_cyc = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   logic [PW-1:0] beat_data [$];
   int            beat_cyc  [$];
   bit            beat_last [$];
   logic [AW-1:0] beat_addr [$];
   int done_cnt = 0, done_cyc = 0, last_cnt = 0, valid_cycles = 0, we_bad = 0;
   logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_rst = 1'b1;
   logic [PW-1:0] prev_data = '0;

   always @(negedge clk) begin : mon
      int c;
      c = edge_cnt - base_cyc;
      if (!rst) begin
         if (sram_write_enable !== 1'b0) we_bad <= we_bad + 1;
         if (strm.m_valid === 1'b1) valid_cycles <= valid_cycles + 1;
         if (prev_valid && !prev_ready && !prev_rst) begin
            check_val("stall_valid", {31'd0, strm.m_valid}, 32'd1);
            check_val("stall_data", {12'd0, strm.m_data}, {12'd0, prev_data});
            check_val("stall_last", {31'd0, strm.m_last}, {31'd0, prev_last});
         end
         if (strm.m_valid && strm.m_ready) begin
            beat_data.push_back(strm.m_data);
            beat_cyc.push_back(c);
            beat_last.push_back(strm.m_last);
            beat_addr.push_back(sram_address);
            if (strm.m_last) last_cnt <= last_cnt + 1;
         end
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= c;
         end
      end
      prev_valid <= strm.m_valid;
      prev_ready <= strm.m_ready;
      prev_data  <= strm.m_data;
      prev_last  <= strm.m_last;
      prev_rst   <= rst;
   end

   // test helpers
   logic [4:0]    rpat = 5'b11111;
   int            rph  = 0;
   logic [PW-1:0] exp_q [$];
   int snap_b, snap_d, snap_l, snap_v;

   task automatic set_lane(input int a, input int l, input logic [PW-1:0] v);
      mem[a][l*PW +: PW] = v;
   endtask

   task automatic build_exp(input int b, input int n);
      logic [AW-1:0] a;
      exp_q.delete();
      for (int w = 0; w < n; w++) begin
         a = AW'(b + w);
         for (int l = 0; l < MS; l++) exp_q.push_back(mem[a][l*PW +: PW]);
      end
   endtask

   task automatic start_drain(input int b, input int n);
      snap_b = beat_data.size();
      snap_d = done_cnt;
      snap_l = last_cnt;
      snap_v = valid_cycles;
      start = 1'b1;
      base_addr = AW'(b);
      num_words = (AW+1)'(n);
      @(posedge clk);
      #1;
      start = 1'b0;
      base_cyc = edge_cnt - 1;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (done_cnt == snap_d && k < budget) begin
         @(posedge clk);
         #1;
         strm.m_ready = rpat[rph];
         rph = (rph + 1) % 5;
         k++;
      end
      if (done_cnt == snap_d) check_val("timeout_done", 32'd0, 32'd1);
      repeat (4) begin
         @(posedge clk);
         #1;
         strm.m_ready = rpat[rph];
         rph = (rph + 1) % 5;
      end
   endtask

   task automatic check_stream(input string tag);
      int n;
      n = beat_data.size() - snap_b;
      check_val({tag, "_beats"}, n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         check_val($sformatf("%s_d%0d", tag, i), {12'd0, beat_data[snap_b+i]}, {12'd0, exp_q[i]});
      check_val({tag, "_last_cnt"}, last_cnt - snap_l, 32'd1);
      if (n > 0) check_val({tag, "_last_pos"}, {31'd0, beat_last[snap_b+n-1]}, 32'd1);
      check_val({tag, "_done_cnt"}, done_cnt - snap_d, 32'd1);
      check_val({tag, "_we"}, we_bad, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      num_words = '0;
      strm.m_ready = 1'b1;
      for (int a = 0; a < 1024; a++) mem[a] = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid", {31'd0, strm.m_valid}, 32'd0);
      check_val("rst_last", {31'd0, strm.m_last}, 32'd0);
      check_val("rst_done", {31'd0, done}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_addr", {22'd0, sram_address}, 32'd0);
      check_val("rst_we", {31'd0, sram_write_enable}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: single word, lanes 1..8, ready always
      for (int l = 0; l < MS; l++) set_lane(0, l, PW'(l + 1));
      exp_q.delete();
      for (int l = 0; l < MS; l++) exp_q.push_back(PW'(l + 1));
      start_drain(0, 1);
      check_val("t1_busy", {31'd0, busy}, 32'd1);
      wait_done(100);
      check_stream("t1");
      check_val("t1_first_cyc", beat_cyc[snap_b], 32'd3);
      check_val("t1_last_cyc", beat_cyc[snap_b+7], 32'd10);
      check_val("t1_done_cyc", done_cyc, 32'd11);

      // 2: eight words, value 16*addr+lane
      for (int a = 0; a < 8; a++)
         for (int l = 0; l < MS; l++) set_lane(a, l, PW'(16*a + l));
      build_exp(0, 8);
      start_drain(0, 8);
      wait_done(200);
      check_stream("t2");
      check_val("t2_beat9", {12'd0, beat_data[snap_b+9]}, 32'd17);
      check_val("t2_done_cyc", done_cyc, 32'd81);

      // 3: negative lane 0, ready pattern 0,1,0,0,1
      set_lane(0, 0, 20'hFFFFB);
      for (int l = 1; l < MS; l++) set_lane(0, l, PW'(20'h80000 + l));
      build_exp(0, 1);
      rpat = 5'b10010;
      rph  = 0;
      start_drain(0, 1);
      wait_done(200);
      check_stream("t3");
      check_val("t3_first", {12'd0, beat_data[snap_b]}, 32'hFFFFB);
      rpat = 5'b11111;
      strm.m_ready = 1'b1;

      // 4: address wrap
      for (int w = 0; w < 4; w++)
         for (int l = 0; l < MS; l++) set_lane((1022 + w) % 1024, l, PW'(20'h30000 + 8*w + l));
      build_exp(1022, 4);
      start_drain(1022, 4);
      wait_done(200);
      check_stream("t4");
      check_val("t4_addr0", {22'd0, beat_addr[snap_b]},    32'd1022);
      check_val("t4_addr1", {22'd0, beat_addr[snap_b+8]},  32'd1023);
      check_val("t4_addr2", {22'd0, beat_addr[snap_b+16]}, 32'd0);
      check_val("t4_addr3", {22'd0, beat_addr[snap_b+24]}, 32'd1);

      // 5a: zero words
      start_drain(0, 0);
      wait_done(50);
      check_val("t5_done_cyc", done_cyc, 32'd1);
      check_val("t5_done_cnt", done_cnt - snap_d, 32'd1);
      check_val("t5_valid", valid_cycles - snap_v, 32'd0);
      check_val("t5_beats", beat_data.size() - snap_b, 32'd0);

      // 5b: start while busy is ignored
      for (int w = 0; w < 3; w++)
         for (int l = 0; l < MS; l++) set_lane(10 + w, l, PW'(20'h50000 + 8*w + l));
      build_exp(10, 3);
      start_drain(10, 3);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      base_addr = 10'd500;
      num_words = 11'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(200);
      check_stream("t5b");
      check_val("t5b_done_cyc", done_cyc, 32'd31);

      // 6: reset during SEND of word 1
      start_drain(0, 4);
      repeat (14) @(posedge clk);
      #1;
      check_val("t6_pre_valid", {31'd0, strm.m_valid}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("t6_valid", {31'd0, strm.m_valid}, 32'd0);
      check_val("t6_busy", {31'd0, busy}, 32'd0);
      check_val("t6_done", {31'd0, done}, 32'd0);
      repeat (40) @(posedge clk);
      #1;
      check_val("t6_no_done", done_cnt - snap_d, 32'd0);
      for (int l = 0; l < MS; l++) set_lane(2, l, PW'(20'h70000 + l));
      build_exp(2, 1);
      start_drain(2, 1);
      wait_done(100);
      check_stream("t6b");
      check_val("t6b_done_cyc", done_cyc, 32'd11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/result_readback.md
Name: result_readback

Overview:
- Drains the result SRAM after a vector-multiply run and streams its contents to the host.
- Reads words of MATRIX_SIZE packed partial sums (PARTIAL_SUM_BW each), one word per address.
- Serializes each word lane by lane onto a valid/ready stream.
- Is the read-side counterpart of the result write path: it sits between the SRAM_Results port and the host, and is triggered once the result SRAM has been filled.

Parameters:
- ADDRESSSIZE, 10, result SRAM address width
- MATRIX_SIZE, 8, partial-sum lanes per SRAM word
- PARTIAL_SUM_BW, 20, bits per lane (signed)

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- start  input  1  pulse; begin a drain
- base_addr  input  ADDRESSSIZE  first SRAM address; sampled on accepted start
- num_words  input  ADDRESSSIZE+1  words to drain; sampled on accepted start
- sram_write_enable  output  1  tied 0; this block never writes
- sram_address  output  ADDRESSSIZE  read address
- sram_data_out  input  PARTIAL_SUM_BW*MATRIX_SIZE  SRAM read data, valid 1 cycle after address
- m_valid  output  1  stream data valid
- m_ready  input  1  stream sink ready
- m_data  output  PARTIAL_SUM_BW  signed partial sum
- m_last  output  1  high with final lane of final word
- busy  output  1  high from cycle after accepted start through DONE
- done  output  1  one-cycle pulse after final handshake

Behaviour:
- Reset values: state IDLE; m_valid, m_last, done, busy all 0; sram_address 0; lane and word counters 0; sram_write_enable is always 0.
- States and transitions:
  - IDLE: on start=1, latch base_addr and num_words, then go to ADDR. If num_words==0, go to DONE instead.
  - ADDR: drive sram_address = base + word_idx, modulo 2^ADDRESSSIZE. Go to WAIT.
  - WAIT: capture sram_data_out into the lane shift register at the cycle end. Go to SEND.
  - SEND: m_valid=1, m_data = current lane. Lane 0 is bits [PARTIAL_SUM_BW-1:0], ascending.
    - Handshake is m_valid & m_ready. On handshake, shift and increment the lane counter.
    - After lane MATRIX_SIZE-1 is accepted: increment word_idx. Go to ADDR if words remain, otherwise go to DONE.
  - DONE: done=1 for exactly one cycle, busy=1. Go to IDLE.
- Stream rules:
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable and m_valid stays high.
  - m_valid never depends combinationally on m_ready.
- m_last = 1 only in SEND, with lane==MATRIX_SIZE-1 and word_idx==num_words-1.
- Timing with m_ready held at 1, start sampled at cycle 0:
  - Word k uses ADDR at cycle 10k+1, WAIT at 10k+2, SEND at 10k+3..10k+10.
  - done pulses at cycle 10N+1.
- start while busy is ignored; latched parameters are unchanged.
- Address wrap: base_addr + word_idx wraps modulo 2^ADDRESSSIZE silently.
- num_words is capped at 2^ADDRESSSIZE; larger values are treated as 2^ADDRESSSIZE.
- rst mid-drain: next cycle is in reset state, m_valid=0, no done pulse. A partially sent word is discarded.
- Sign: m_data is the raw lane bits; no extension or saturation.

Decomposition:
- Package result_readback_pkg:
  - state enum {IDLE, ADDR, WAIT, SEND, DONE}
  - localparams WORD_W = PARTIAL_SUM_BW*MATRIX_SIZE, LANE_CNT_W = clog2(MATRIX_SIZE)
- One sub-module: psum_word_serializer.
  - Ports: load, shift, word in; lane out; lane counter with last_lane flag.
  - Instantiated once.
  - FSM, address generation and stream control stay in result_readback.

Test Plan:
1. Preload address 0 with lanes 1..8, m_ready=1; start with base=0, num=1. Expect m_data sequence 1,2,…,8 at cycles 3..10, m_last at cycle 10, done at cycle 11, sram_write_enable=0 throughout.
2. Preload addresses 0..7 with value 16*addr+lane; start with num=8, m_ready=1. Expect 64 beats in order, exactly one m_last (final beat), done at cycle 81.
3. num=1, lane 0 = -5 (20'hFFFFB); m_ready toggles 0,1,0,0,1,… Expect m_data/m_valid stable during stalls, exactly 8 handshakes, first beat 20'hFFFFB, no lost or duplicated lanes.
4. base=1022, num=4. Expect read addresses 1022, 1023, 0, 1 in that order.
5. num=0. Expect done at cycle 1, m_valid never asserted. Second start pulse during a num=3 drain is ignored: exactly 24 beats.
6. Assert rst for one cycle during SEND of word 1 of a num=4 drain. Expect m_valid=0 and busy=0 the next cycle, no done. A fresh start with num=1 then drains correctly.
